// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline: reset vector, bubble word,
// opcodes referenced by fetch/decode, and the machine word type.
package mips_pkg;
    typedef logic [31:0] word_t;

    localparam word_t RESET_PC = 32'h0000_3000;
    localparam word_t NOP      = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC helper: sequential PC+4 and the prioritised redirect
// target (jr over jump over branch) formed from decode-stage operands.
module npc_calc
    import mips_pkg::*;
(
    input  word_t       pc,
    input  word_t       pc_plus4_d,
    input  logic [25:0] instr_index,
    input  word_t       sign_imm,
    input  word_t       reg_target,
    input  logic        jr,
    input  logic        jump,
    input  logic        branch,
    output word_t       pc_plus4,
    output word_t       target,
    output logic        redirect
);
    word_t jump_target;
    word_t branch_target;

    // Both adds wrap silently modulo 2^32.
    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4_d[31:28], instr_index, 2'b00};
    assign branch_target = pc_plus4_d + {sign_imm[29:0], 2'b00};
    assign redirect      = jr | jump | branch;

    always_comb begin
        target = branch_target;
        if (jr) begin
            target = reg_target;
        end else if (jump) begin
            target = jump_target;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, and a two-state
// FSM that buffers a redirect arriving under stall until the stall releases.
module fetch_unit
    import mips_pkg::*;
#(
    parameter word_t RESET_PC = mips_pkg::RESET_PC,
    parameter word_t NOP      = mips_pkg::NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        BranchD,
    input  logic [31:0] SignImmD,
    input  logic        JumpD,
    input  logic        JrD,
    input  logic [31:0] RegTargetD,
    input  logic [31:0] ImemData,
    output logic [31:0] ImemAddr,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCPlus8D,
    output logic        RedirectPending
);
    fetch_state_t state;
    word_t        pc;
    word_t        pend_tgt;
    word_t        pc_plus4;
    word_t        target;
    logic         redirect;

    npc_calc u_npc_calc (
        .pc          (pc),
        .pc_plus4_d  (PCPlus4D),
        .instr_index (InstrD[25:0]),
        .sign_imm    (SignImmD),
        .reg_target  (RegTargetD),
        .jr          (JrD),
        .jump        (JumpD),
        .branch      (BranchD),
        .pc_plus4    (pc_plus4),
        .target      (target),
        .redirect    (redirect)
    );

    // A redirect seen in the release cycle itself is newer than the buffered one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_RUN;
            pc       <= RESET_PC;
            pend_tgt <= '0;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (!StallF) begin
                        pc <= redirect ? target : pc_plus4;
                    end else if (redirect) begin
                        pend_tgt <= target;
                        state    <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (StallF) begin
                        if (redirect) begin
                            pend_tgt <= target;
                        end
                    end else begin
                        pc    <= redirect ? target : pend_tgt;
                        state <= FETCH_RUN;
                    end
                end
                default: state <= FETCH_RUN;
            endcase
        end
    end

    // Flush beats stall so a squashed slot never survives a held pipeline.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP;
            PCPlus4D <= '0;
        end else if (!StallF) begin
            InstrD   <= ImemData;
            PCPlus4D <= pc_plus4;
        end
    end

    assign ImemAddr        = pc;
    assign PCPlus8D        = PCPlus4D + 32'd4;
    assign RedirectPending = (state == FETCH_HOLD);
endmodule
